// File: rtl/baud_tick_gen_if.sv
// baud_tick_gen_if: control and tick bundle between a UART block (master)
// and its baud-rate tick generator (slave).
interface baud_tick_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              resync;
    logic              os_tick;
    logic              mid_tick;
    logic              bit_tick;
    logic              div_pending;

    modport master (
        output en, div_int, div_frac, div_load, resync,
        input  os_tick, mid_tick, bit_tick, div_pending
    );

    modport slave (
        input  en, div_int, div_frac, div_load, resync,
        output os_tick, mid_tick, bit_tick, div_pending
    );
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable baud tick generator. Emits single-cycle
// clock-enable pulses for the oversample tick, the mid-bit sample point and
// the bit boundary. The divisor is double-buffered: a load lands in a shadow
// register and becomes active at the next bit boundary, on resync, or on the
// next cycle while counting is disabled.
// Optional feature macro: BAUD_FRAC_EN builds the fractional accumulator so
// that div_frac stretches periods by one clock on each accumulator carry.
module baud_tick_gen #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_RESET  = 8
) (
    input  logic            clk,
    input  logic            rst,
    baud_tick_gen_if.slave  bus
);
    localparam int            OS_W    = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_W-1:0] clk_cnt;
    logic [OS_W-1:0]  os_cnt;
    logic [DIV_W-1:0] div_int_act;
    logic [DIV_W-1:0] div_int_sh;
    logic             pending;
    logic             os_tick_r;
    logic             mid_tick_r;
    logic             bit_tick_r;

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W:0]   period_last;
    logic             carry;
    logic             terminal;
    logic             boundary;
    logic             apply;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_acc;
    logic [FRAC_W-1:0] div_frac_act;
    logic [FRAC_W-1:0] div_frac_sh;
    logic [FRAC_W:0]   frac_sum;

    assign frac_sum = {1'b0, frac_acc} + {1'b0, div_frac_act};
    assign carry    = frac_sum[FRAC_W];
`else
    // div_frac has no effect in the integer-only build.
    logic frac_unused;
    assign frac_unused = ^bus.div_frac;
    assign carry       = 1'b0;
`endif

    // A zero divisor behaves as one so the generator never stalls.
    assign div_eff     = (div_int_act == '0) ? DIV_W'(1) : div_int_act;
    assign period_last = {1'b0, div_eff} + {{DIV_W{1'b0}}, carry} - (DIV_W+1)'(1);

    // ">=" keeps the counter from running away if a disabled-state divisor
    // swap shrinks the period below the count already reached.
    assign terminal = bus.en && !bus.resync && ({1'b0, clk_cnt} >= period_last);
    assign boundary = terminal && (os_cnt == OS_LAST);
    assign apply    = pending && (bus.resync || boundary || !bus.en);

    // Period and oversample counters; resync restarts the bit phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_cnt <= '0;
            os_cnt  <= '0;
`ifdef BAUD_FRAC_EN
            frac_acc <= '0;
`endif
        end else if (bus.resync) begin
            clk_cnt <= '0;
            os_cnt  <= '0;
`ifdef BAUD_FRAC_EN
            frac_acc <= '0;
`endif
        end else if (terminal) begin
            clk_cnt <= '0;
            os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
`ifdef BAUD_FRAC_EN
            frac_acc <= frac_sum[FRAC_W-1:0];
`endif
        end else if (bus.en) begin
            clk_cnt <= clk_cnt + DIV_W'(1);
        end
    end

    // Registered tick pulses, one cycle after the terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            os_tick_r  <= 1'b0;
            mid_tick_r <= 1'b0;
            bit_tick_r <= 1'b0;
        end else begin
            os_tick_r  <= terminal;
            mid_tick_r <= terminal && (os_cnt == OS_MID);
            bit_tick_r <= boundary;
        end
    end

    // Shadow/active divisor handoff; a load always wins over the clear of
    // pending, so a load coincident with an apply waits for the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_int_act <= DIV_W'(DIV_RESET);
            div_int_sh  <= DIV_W'(DIV_RESET);
`ifdef BAUD_FRAC_EN
            div_frac_act <= '0;
            div_frac_sh  <= '0;
`endif
            pending <= 1'b0;
        end else begin
            if (apply) begin
                div_int_act <= div_int_sh;
`ifdef BAUD_FRAC_EN
                div_frac_act <= div_frac_sh;
`endif
            end
            if (bus.div_load) begin
                div_int_sh <= bus.div_int;
`ifdef BAUD_FRAC_EN
                div_frac_sh <= bus.div_frac;
`endif
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    assign bus.os_tick     = os_tick_r;
    assign bus.mid_tick    = mid_tick_r;
    assign bus.bit_tick    = bit_tick_r;
    assign bus.div_pending = pending;
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed bench for baud_tick_gen. Expected tick cycles
// are queued when stimulus is applied and consumed as the DUT emits ticks.
// Cycle numbers count rising edges from the last phase origin.
module tb_baud_tick_gen;
    localparam int DIV_W     = 16;
    localparam int FRAC_W    = 4;
    localparam int OS        = 16;
    localparam int DIV_RESET = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    baud_tick_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

    baud_tick_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS), .DIV_RESET(DIV_RESET)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;
    int exp_os[$];
    int exp_mid[$];
    int exp_bit[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, sample just after it, score any tick.
    task automatic cycle();
        bit want;
        @(posedge clk);
        #1;
        cyc++;
        if (chk_on) begin
            want = (exp_os.size() > 0) && (exp_os[0] == cyc);
            if (want || bus.os_tick) begin
                chk($sformatf("os_tick@%0d", cyc), {31'd0, bus.os_tick}, {31'd0, want});
                if (want) void'(exp_os.pop_front());
            end
            want = (exp_mid.size() > 0) && (exp_mid[0] == cyc);
            if (want || bus.mid_tick) begin
                chk($sformatf("mid_tick@%0d", cyc), {31'd0, bus.mid_tick}, {31'd0, want});
                if (want) void'(exp_mid.pop_front());
            end
            want = (exp_bit.size() > 0) && (exp_bit[0] == cyc);
            if (want || bus.bit_tick) begin
                chk($sformatf("bit_tick@%0d", cyc), {31'd0, bus.bit_tick}, {31'd0, want});
                if (want) void'(exp_bit.pop_front());
            end
        end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) cycle();
    endtask

    task automatic push_os(input int first, input int step, input int n);
        for (int k = 0; k < n; k++) exp_os.push_back(first + k * step);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_os_left"},  exp_os.size(),  0);
        chk({tag, "_mid_left"}, exp_mid.size(), 0);
        chk({tag, "_bit_left"}, exp_bit.size(), 0);
        exp_os.delete();
        exp_mid.delete();
        exp_bit.delete();
    endtask

    // Load a divisor for one cycle, then resync; returns the resync cycle.
    task automatic load_resync(input int di, input int df, output int n);
        bus.div_int  = DIV_W'(di);
        bus.div_frac = FRAC_W'(df);
        bus.div_load = 1'b1;
        cycle();
        chk("load_sets_pending", {31'd0, bus.div_pending}, 1);
        bus.div_load = 1'b0;
        bus.resync   = 1'b1;
        cycle();
        n = cyc;
        chk("resync_no_os", {31'd0, bus.os_tick}, 0);
        chk("resync_clears_pending", {31'd0, bus.div_pending}, 0);
        bus.resync = 1'b0;
    endtask

    initial begin
        int n;
        int t;
        int l;
        bus.en       = 1'b1;
        bus.div_int  = '0;
        bus.div_frac = '0;
        bus.div_load = 1'b0;
        bus.resync   = 1'b0;

        // Outputs while reset is held.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_os",      {31'd0, bus.os_tick},     0);
        chk("rst_mid",     {31'd0, bus.mid_tick},    0);
        chk("rst_bit",     {31'd0, bus.bit_tick},    0);
        chk("rst_pending", {31'd0, bus.div_pending}, 0);

        // Reset divisor: os every 8, mid at 64, bit at 128.
        rst = 1'b1;
        cyc = 0;
        push_os(8, 8, 16);
        exp_mid.push_back(64);
        exp_bit.push_back(128);
        chk_on = 1'b1;
        run_to(130);
        chk_on = 1'b0;
        drained("reset_div");

        // Integer divisor 3 after resync.
        load_resync(3, 0, n);
        push_os(n + 3, 3, 16);
        exp_mid.push_back(n + 24);
        exp_bit.push_back(n + 48);
        chk_on = 1'b1;
        run_to(n + 48);
        chk_on = 1'b0;
        drained("int3");

        // Fractional divisor 3 + 8/16.
        load_resync(3, 8, n);
        t = n;
        for (int k = 0; k < 16; k++) begin
`ifdef BAUD_FRAC_EN
            t += (k % 2 == 0) ? 3 : 4;
`else
            t += 3;
`endif
            exp_os.push_back(t);
            if (k == 7)  exp_mid.push_back(t);
            if (k == 15) exp_bit.push_back(t);
        end
        chk_on = 1'b1;
        run_to(t);
        chk_on = 1'b0;
        drained("frac");

        // Deferred load: 5 takes effect only at the bit boundary.
        load_resync(3, 0, n);
        push_os(n + 3, 3, 16);
        push_os(n + 53, 5, 16);
        exp_mid.push_back(n + 24);
        exp_bit.push_back(n + 48);
        exp_mid.push_back(n + 88);
        exp_bit.push_back(n + 128);
        chk_on = 1'b1;
        run_to(n + 10);
        bus.div_int  = DIV_W'(5);
        bus.div_load = 1'b1;
        cycle();
        chk("deferred_pending_set", {31'd0, bus.div_pending}, 1);
        bus.div_load = 1'b0;
        run_to(n + 47);
        chk("deferred_pending_hold", {31'd0, bus.div_pending}, 1);
        cycle();
        chk("deferred_pending_clr", {31'd0, bus.div_pending}, 0);
        run_to(n + 128);

        // Resync coincident with a terminal count.
        t = n + 133;
        run_to(t - 1);
        bus.resync = 1'b1;
        cycle();
        chk("resync_tc_no_os", {31'd0, bus.os_tick}, 0);
        bus.resync = 1'b0;
        push_os(t + 5, 5, 16);
        exp_mid.push_back(t + 40);
        exp_bit.push_back(t + 80);
        run_to(t + 81);

        // en low for 10 edges stretches the period by 10.
        bus.en = 1'b0;
        run_to(t + 91);
        chk("en_low_os", {31'd0, bus.os_tick}, 0);
        bus.en = 1'b1;
        exp_os.push_back(t + 95);
        exp_os.push_back(t + 100);
        run_to(t + 100);
        chk_on = 1'b0;
        drained("resync_en");

        // Divisor 0 behaves as 1.
        load_resync(0, 0, n);
        push_os(n + 1, 1, 16);
        exp_mid.push_back(n + 8);
        exp_bit.push_back(n + 16);
        chk_on = 1'b1;
        run_to(n + 16);

        // Load while disabled applies on the next cycle.
        bus.en       = 1'b0;
        bus.div_int  = DIV_W'(4);
        bus.div_load = 1'b1;
        cycle();
        l = cyc;
        chk("dis_load_pending", {31'd0, bus.div_pending}, 1);
        bus.div_load = 1'b0;
        cycle();
        chk("dis_load_applied", {31'd0, bus.div_pending}, 0);
        bus.en = 1'b1;
        exp_os.push_back(l + 5);
        exp_os.push_back(l + 9);
        run_to(l + 9);

        // Async reset mid-bit with a tick high and a divisor pending.
        bus.div_int  = DIV_W'(5);
        bus.div_load = 1'b1;
        cycle();
        bus.div_load = 1'b0;
        chk("pre_rst_pending", {31'd0, bus.div_pending}, 1);
        exp_os.push_back(l + 13);
        run_to(l + 13);
        chk_on = 1'b0;
        drained("div0_dis");
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_os",      {31'd0, bus.os_tick},     0);
        chk("async_rst_pending", {31'd0, bus.div_pending}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        push_os(8, 8, 4);
        chk_on = 1'b1;
        run_to(32);
        chk_on = 1'b0;
        drained("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Programmable baud-rate tick generator for the UART datapath. It produces an oversample tick, a mid-bit sample tick and a bit tick from one system clock. The divisor is set at runtime and may include an optional fractional part. The bit phase can be realigned for the RX start-bit detector. TX and RX each instantiate one copy; all outputs are single-cycle clock-enable pulses, never derived clocks.

## Interface
- `DIV_W`, 16: width of the integer divisor (system clocks per oversample tick).
- `FRAC_W`, 4: width of the fractional divisor, in units of 1/2^FRAC_W clock.
- `OVERSAMPLE`, 16: oversample ticks per bit; even, ≥2.
- `DIV_RESET`, 8: integer divisor active out of reset.

- `clk`  in  1  system clock; one clock only.
- `rst`  in  1  reset; asynchronous, active-low.
- `en`  in  1  count enable; when low, all counters hold.
- `div_int`  in  DIV_W  integer divisor; 0 is treated as 1.
- `div_frac`  in  FRAC_W  fractional divisor.
- `div_load`  in  1  one-cycle strobe; captures `div_int`/`div_frac` into the shadow register.
- `resync`  in  1  synchronous phase restart.
- `os_tick`  out  1  oversample tick pulse.
- `mid_tick`  out  1  mid-bit sample pulse.
- `bit_tick`  out  1  bit boundary pulse.
- `div_pending`  out  1  shadow divisor captured but not yet active.

## Operation
- Internal state:
  - `clk_cnt`[DIV_W]: clocks within the current oversample period.
  - `os_cnt`[$clog2(OVERSAMPLE)]: oversample ticks within the current bit.
  - `frac_acc`[FRAC_W]: fractional accumulator.
  - Active divisor and shadow divisor.
- Period length: P = max(div_int_active,1) + c, where c = carry-out of (`frac_acc` + `div_frac_active`) at FRAC_W bits.
- Terminal count is `clk_cnt` == P−1 with `en`=1. On terminal count:
  - `clk_cnt` <= 0.
  - `frac_acc` <= (`frac_acc` + `div_frac_active`) mod 2^FRAC_W.
  - `os_tick` <= 1.
  - `os_cnt` increments, wrapping at OVERSAMPLE−1 → 0.
- `mid_tick` <= 1 on a terminal count where `os_cnt` == OVERSAMPLE/2−1.
- `bit_tick` <= 1 on a terminal count where `os_cnt` == OVERSAMPLE−1. This is the bit boundary.
- Divisor update:
  - `div_load` copies the inputs into the shadow register and sets `div_pending`.
  - The shadow becomes active at the next bit boundary or `resync`, and `div_pending` clears in the same cycle.
  - If `en`=0, the shadow becomes active on the cycle after the load.
  - A `div_load` on the same cycle as a boundary is applied at the following boundary.
  - A second `div_load` while pending overwrites the shadow.
- `resync`:
  - Clears `clk_cnt`, `os_cnt` and `frac_acc`, applies any pending shadow, and suppresses all ticks for that cycle.
  - Priority over `en` and over a coincident terminal count.
- `en` low: all state holds; outputs are 0 on the next cycle. Counting resumes from the held values.
- Reset values:
  - All outputs 0; all counters 0.
  - Active divisor = {DIV_RESET, 0}; shadow = {DIV_RESET, 0}.
  - `div_pending` = 0.
- Reset mid-bit discards the phase and any pending divisor.

## Timing
- All outputs are registered. A tick is high for exactly one cycle, in the cycle after its terminal count.
- With `en` high from reset release and P constant, `os_tick` is first high after P rising edges, then every P cycles.
- `bit_tick` coincides with every OVERSAMPLE-th `os_tick`. `mid_tick` coincides with the (OVERSAMPLE/2)-th `os_tick` of each bit.
- After `resync` at cycle N, the first `os_tick` is high at cycle N+P.
- `mid_tick` after `resync` follows (OVERSAMPLE/2)·P cycles later, the RX start-bit centre.
- Divisor changes never shorten or stretch a period already in progress except through `resync`.

## Configuration
- `BAUD_FRAC_EN` defined: fractional accumulator and carry logic are built; `div_frac` is honoured.
- `BAUD_FRAC_EN` undefined:
  - `frac_acc` and the shadow fractional bits are not built; `div_frac` is ignored.
  - P = max(div_int_active,1) exactly, with all other behaviour identical.

## Test plan
- Reset-value check (OVERSAMPLE=16): hold `en`=1 with no load → `os_tick` every 8 cycles, `bit_tick` every 128, all outputs 0 during reset.
- Integer divisor: `div_load` with `div_int`=3, `div_frac`=0, then `resync` → `os_tick` every 3 cycles, `mid_tick` 24 cycles and `bit_tick` 48 cycles after `resync`.
- Fractional divisor (`BAUD_FRAC_EN`): `div_int`=3, `div_frac`=8 → periods alternate 3,4,3,4, giving 16 `os_tick`s in 56 cycles. Without the macro, 48 cycles.
- Deferred load: mid-bit `div_load` with `div_int`=5 → `div_pending`=1; old period persists until `bit_tick`, then 5-cycle periods begin and `div_pending`=0.
- `resync` coincident with a terminal count → no tick that cycle; next `os_tick` P cycles later; `os_cnt` restarts at 0.
- Edge cases:
  - `div_int`=0 → `os_tick` every cycle.
  - `en` dropped for 10 cycles mid-period → period extended by exactly 10 cycles.
  - Async `rst` mid-bit → outputs 0 immediately and active divisor = DIV_RESET.
